// File: rtl/spiker_adapter_pkg.sv
// rtl/spiker_adapter_pkg.sv - shared types and constants for the Spiker adapter
package spiker_adapter_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, WRITE} reader_state_e;

  localparam int RESULT_VALID_BIT = 31;
  localparam int RESULT_OVR_BIT   = 16;
  localparam int RESULT_IDX_W     = 16;

  typedef struct packed {
    logic start;
    logic clear;
  } spiker_adapter_reg2hw_t;

  typedef struct packed {
    logic cnt_de;
    logic result_de;
    logic irq;
  } spiker_adapter_hw2reg_t;

  function automatic int n_cnt_reg(input int n_out, input int cnt_width, input int width);
    return (n_out * cnt_width + width - 1) / width;
  endfunction

endpackage

// File: rtl/spiker_spike_counter.sv
// rtl/spiker_spike_counter.sv - saturating per-neuron spike counter
module spiker_spike_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/spiker_result_reader.sv
// rtl/spiker_result_reader.sv - spike accumulation, sequential argmax and hw2reg write-back
module spiker_result_reader
  import spiker_adapter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N_OUT     = 10,
  parameter int CNT_WIDTH = 8,
  parameter int N_STEPS   = 100,
  localparam int N_CNT_REG = n_cnt_reg(N_OUT, CNT_WIDTH, WIDTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       clear_i,
  input  logic [N_OUT-1:0]           spikes_i,
  input  logic                       spikes_valid_i,
  output logic                       busy_o,
  output logic [N_CNT_REG*WIDTH-1:0] cnt_d_o,
  output logic                       cnt_de_o,
  output logic [WIDTH-1:0]           result_d_o,
  output logic                       result_de_o,
  output logic                       irq_o
);

  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int STEP_W = $clog2(N_STEPS + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_OUT - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  spiker_adapter_reg2hw_t reg2hw;
  spiker_adapter_hw2reg_t hw2reg_q;

  reader_state_e         state_q;
  logic [STEP_W-1:0]     step_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      best_idx_q;
  logic [CNT_WIDTH-1:0]  best_cnt_q;
  logic                  ovr_q;
  logic [WIDTH-1:0]      result_q;

  logic [CNT_WIDTH-1:0]  cnt [N_OUT];
  logic                  start_ok;
  logic                  cnt_clr;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  cur_cnt;
  logic                  take;
  logic [IDX_W-1:0]      win_idx;
  logic                  ovr_now;
  logic [WIDTH-1:0]      result_next;

  assign reg2hw   = '{start: start_i, clear: clear_i};
  assign start_ok = reg2hw.start && (state_q == IDLE);
  assign cnt_clr  = reg2hw.clear || start_ok;
  assign accept   = (state_q == ACCUM) && spikes_valid_i;

  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    spiker_spike_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cnt_clr),
      .inc_i (accept && spikes_i[k]),
      .cnt_o (cnt[k])
    );
  end

  // Strict compare keeps the earlier (lower) index on ties.
  assign cur_cnt = cnt[idx_q];
  assign take    = cur_cnt > best_cnt_q;
  assign win_idx = take ? idx_q : best_idx_q;
  assign ovr_now = ovr_q || ((state_q == ARGMAX) && spikes_valid_i);

  always_comb begin
    result_next = '0;
    result_next[RESULT_IDX_W-1:0] = RESULT_IDX_W'(win_idx);
    result_next[RESULT_OVR_BIT]   = ovr_now;
    result_next[RESULT_VALID_BIT] = 1'b1;
  end

  always_comb begin
    cnt_d_o = '0;
    for (int k = 0; k < N_OUT; k++) begin
      cnt_d_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || reg2hw.clear) begin
      state_q    <= IDLE;
      step_q     <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      ovr_q      <= 1'b0;
      result_q   <= '0;
      hw2reg_q   <= '0;
    end else begin
      hw2reg_q <= '0;
      case (state_q)
        IDLE: begin
          if (reg2hw.start) begin
            state_q  <= ACCUM;
            step_q   <= '0;
            ovr_q    <= 1'b0;
            result_q <= '0;
          end
        end
        ACCUM: begin
          if (spikes_valid_i) begin
            step_q <= step_q + STEP_W'(1);
            if (step_q == LAST_STEP) begin
              state_q    <= ARGMAX;
              idx_q      <= '0;
              best_idx_q <= '0;
              best_cnt_q <= '0;
            end
          end
        end
        ARGMAX: begin
          ovr_q      <= ovr_now;
          best_idx_q <= win_idx;
          best_cnt_q <= take ? cur_cnt : best_cnt_q;
          idx_q      <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q  <= WRITE;
            result_q <= result_next;
            hw2reg_q <= '{cnt_de: 1'b1, result_de: 1'b1, irq: 1'b1};
          end
        end
        WRITE: begin
          if (spikes_valid_i) ovr_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign result_d_o  = result_q;
  assign cnt_de_o    = hw2reg_q.cnt_de;
  assign result_de_o = hw2reg_q.result_de;
  assign irq_o       = hw2reg_q.irq;

endmodule
